serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor, diff = a - b, with a final borrow-out.

---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/serial_subtractor_fs.sv | 28 ++
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : 2-bit FSM encoding (IDLE=0, SHIFT=1, DONE=2; 3 is unused
//                   and is steered back to IDLE by the next-state logic)
//   DEFAULT_WIDTH : default operand/result width
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_fs.sv
// Gate-level full-subtractor cell: d = a - b - bin, one bit.
//   a, b, bin : input bits (minuend, subtrahend, borrow-in)
//   d         : difference bit
//   bout      : borrow-out
module fs (
    output logic d,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    logic a_xor_b;
    logic a_n;
    logic axb_n;
    logic borrow_ab;
    logic borrow_in;

    xor g_x1 (a_xor_b, a, b);
    xor g_x2 (d, a_xor_b, bin);
    not g_n1 (a_n, a);
    not g_n2 (axb_n, a_xor_b);
    // Borrow when a=0,b=1, or when a==b and a borrow comes in.
    and g_a1 (borrow_ab, a_n, b);
    and g_a2 (borrow_in, axb_n, bin);
    or  g_o1 (bout, borrow_ab, borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b (mod 2^WIDTH), bout = (a < b).
// One bit per clock, LSB first, through a single full-subtractor cell; the
// borrow is carried between bits in a flip-flop.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request, sampled only in IDLE
//   a, b  : operands, latched on the edge that accepts start
//   busy  : high while shifting
//   done  : one-cycle pulse, diff/bout valid
//   diff  : registered result, held until the next completion
//   bout  : registered final borrow (unsigned a < b)
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] d_sh_reg;
    logic             borrow_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;

    logic cell_d;
    logic cell_bout;
    logic last_bit;

    fs u_fs (
        .d    (cell_d),
        .bout (cell_bout),
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (borrow_reg)
    );

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_SHIFT;
            S_SHIFT: if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            d_sh_reg   <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_sh_reg   <= a;
                        b_sh_reg   <= b;
                        borrow_reg <= 1'b0;
                        cnt_reg    <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    d_sh_reg   <= {cell_d, d_sh_reg[WIDTH-1:1]};
                    borrow_reg <= cell_bout;
                    cnt_reg    <= cnt_reg + CW'(1);
                    // Capture the fully assembled word including this edge's bit.
                    if (last_bit) begin
                        diff_reg <= {cell_d, d_sh_reg[WIDTH-1:1]};
                        bout_reg <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == S_SHIFT);
    assign done = (state_reg == S_DONE);
    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = idle, 1..W = bit-serial work, W+1 = done.
    int           m_phase = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_diff = '0;
    logic         m_bout = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_diff  = '0;
            m_bout  = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1;
                m_a = a;
                m_b = b;
            end
        end else if (m_phase == W + 1) begin
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == W + 1) begin
                m_diff = m_a - m_b;
                m_bout = (m_a < m_b);
            end
        end
    end

    // Per-cycle compare against the model, plus done bookkeeping.
    bit chk_en = 0;
    int cyc = 0;
    int done_seen = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_seen++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
        end
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= W));
            check("done", 32'(done), 32'(m_phase == W + 1));
            check("diff", 32'(diff), 32'(m_diff));
            check("bout", 32'(bout), 32'(m_bout));
            check("busy_and_done", 32'(busy & done), 32'd0);
        end
    end

    // One transaction: pulse start, wait (bounded) for done, check result and latency.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] exp_d, input logic exp_b);
        int edges;
        bit got;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        got = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #2;
            edges++;
            if (done === 1'b1) begin got = 1; break; end
        end
        check("done_seen", 32'(got), 32'd1);
        // edges counts the accept edge as 1; done follows W edges after it.
        check("latency", 32'(edges - 1), 32'(W));
        check("op_diff", 32'(diff), 32'(exp_d));
        check("op_bout", 32'(bout), 32'(exp_b));
        $display("op a=%02h b=%02h -> diff=%02h bout=%0d", ta, tb_v, diff, bout);
        @(posedge clk);
    endtask

    initial begin
        int d0, p;
        // Reset state after the first clock with rst high.
        @(posedge clk); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1;

        // Directed vectors with hand-computed results.
        run_op(8'h05, 8'h03, 8'h02, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1);
        run_op(8'h00, 8'hFF, 8'h01, 1'b1);
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0);
        run_op(8'h80, 8'h80, 8'h00, 1'b0);

        // start pulsed during SHIFT is ignored; operand changes have no effect.
        d0 = done_seen;
        @(negedge clk); start = 1'b1; a = 8'h05; b = 8'h03;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'h00; b = 8'h01;
        @(negedge clk); start = 1'b0; a = 8'hAA; b = 8'h55;
        repeat (14) @(negedge clk);
        check("ignored_start_pulses", 32'(done_seen - d0), 32'd1);
        check("ignored_start_diff", 32'(diff), 32'h02);
        $display("ignored-start op -> diff=%02h pulses=%0d", diff, done_seen - d0);

        // Reset in the middle of SHIFT.
        d0 = done_seen;
        @(negedge clk); start = 1'b1; a = 8'h05; b = 8'h03;
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (W + 2) @(negedge clk);
        check("midrst_no_done", 32'(done_seen - d0), 32'd0);
        $display("mid-op reset -> outputs cleared, pulses=%0d", done_seen - d0);
        run_op(8'h10, 8'h01, 8'h0F, 1'b0);

        // start held high: back-to-back operations every W+2 cycles.
        d0 = done_seen;
        @(negedge clk); start = 1'b1; a = 8'h09; b = 8'h04;
        for (int i = 0; i < 4 * (W + 2) && (done_seen - d0) < 2; i++) @(negedge clk);
        start = 1'b0;
        check("held_start_pulses", 32'(done_seen - d0), 32'd2);
        p = last_done_cyc - prev_done_cyc;
        check("held_start_period", 32'(p), 32'(W + 2));
        check("held_start_diff", 32'(diff), 32'h05);
        $display("held-start -> period=%0d diff=%02h", p, diff);
        repeat (W + 3) @(negedge clk);

        // Strided sweep across the operand space.
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                logic [W-1:0] sa, sb, sd;
                sa = W'(i * 8 + (i % 8));
                sb = W'(j * 8 + ((j * 5) % 8));
                sd = W'(int'(sa) - int'(sb));
                run_op(sa, sb, sd, (int'(sa) < int'(sb)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule
